// File: rtl/alu_reservation_station_pkg.sv
// ============================================================================
// alu_reservation_station_pkg : opcodes and shared constants for the ALU RS
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_reservation_station_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam int ROB_NONE = 0;

  localparam int AGE_W = 3;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/alu_reservation_station_alu_exec.sv
// ============================================================================
// alu_exec : single-cycle combinational integer ALU, (op, a, b) -> result
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  import alu_reservation_station_pkg::*;

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = XLEN'($signed(a) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      // unknown opcodes still broadcast, with a zero result
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_reservation_station.sv
// ============================================================================
// alu_reservation_station : Tomasulo RS with oldest-ready issue into an ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_reservation_station #(
  parameter int RS_N  = 4,
  parameter int ROB_W = 3,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_op,
  input  logic [ROB_W-1:0] disp_rob_idx,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [ROB_W-1:0] ext_cdb_idx,
  input  logic [XLEN-1:0]  ext_cdb_data,
  output logic [ROB_W-1:0] cdb_alu_rob_idx,
  output logic [XLEN-1:0]  cdb_alu_data
);
  import alu_reservation_station_pkg::*;

  localparam int IDX_W = (RS_N > 1) ? $clog2(RS_N) : 1;

  logic [RS_N-1:0]  valid_q, valid_d;
  logic [3:0]       op_q  [RS_N];
  logic [3:0]       op_d  [RS_N];
  logic [ROB_W-1:0] rob_q [RS_N];
  logic [ROB_W-1:0] rob_d [RS_N];
  logic [XLEN-1:0]  vj_q  [RS_N];
  logic [XLEN-1:0]  vj_d  [RS_N];
  logic [ROB_W-1:0] qj_q  [RS_N];
  logic [ROB_W-1:0] qj_d  [RS_N];
  logic [XLEN-1:0]  vk_q  [RS_N];
  logic [XLEN-1:0]  vk_d  [RS_N];
  logic [ROB_W-1:0] qk_q  [RS_N];
  logic [ROB_W-1:0] qk_d  [RS_N];
  logic [AGE_W-1:0] age_q [RS_N];
  logic [AGE_W-1:0] age_d [RS_N];

  logic [ROB_W-1:0] cdb_idx_q, cdb_idx_d;
  logic [XLEN-1:0]  cdb_data_q, cdb_data_d;

  logic [RS_N-1:0]  ready;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] best_age;
  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             disp_fire;
  logic [XLEN-1:0]  alu_result;

  function automatic logic tag_hit(input logic [ROB_W-1:0] q, input logic [ROB_W-1:0] bus);
    return (bus != ROB_W'(ROB_NONE)) && (q == bus);
  endfunction

  for (genvar g = 0; g < RS_N; g++) begin : g_ready
    assign ready[g] = valid_q[g] && (qj_q[g] == '0) && (qk_q[g] == '0);
  end

  // strict '>' keeps the lowest index on equal ages
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < RS_N; i++) begin
      if (ready[i] && (!sel_found || (age_q[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = RS_N - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = alloc_found;
  assign disp_fire  = disp_valid && alloc_found && !flush;

  alu_exec #(.XLEN(XLEN)) u_alu_exec (
    .op     (op_q[sel_idx]),
    .a      (vj_q[sel_idx]),
    .b      (vk_q[sel_idx]),
    .result (alu_result)
  );

  always_comb begin
    valid_d    = valid_q;
    op_d       = op_q;
    rob_d      = rob_q;
    vj_d       = vj_q;
    qj_d       = qj_q;
    vk_d       = vk_q;
    qk_d       = qk_q;
    age_d      = age_q;
    cdb_idx_d  = cdb_idx_q;
    cdb_data_d = cdb_data_q;

    if (flush) begin
      valid_d   = '0;
      cdb_idx_d = ROB_W'(ROB_NONE);
      for (int i = 0; i < RS_N; i++) age_d[i] = '0;
    end else begin
      // wakeup and aging; the ALU bus takes priority on a tag collision
      for (int i = 0; i < RS_N; i++) begin
        if (valid_q[i]) begin
          if (tag_hit(qj_q[i], cdb_idx_q)) begin
            vj_d[i] = cdb_data_q;
            qj_d[i] = '0;
          end else if (tag_hit(qj_q[i], ext_cdb_idx)) begin
            vj_d[i] = ext_cdb_data;
            qj_d[i] = '0;
          end
          if (tag_hit(qk_q[i], cdb_idx_q)) begin
            vk_d[i] = cdb_data_q;
            qk_d[i] = '0;
          end else if (tag_hit(qk_q[i], ext_cdb_idx)) begin
            vk_d[i] = ext_cdb_data;
            qk_d[i] = '0;
          end
          if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
        end
      end

      if (sel_found) begin
        valid_d[sel_idx] = 1'b0;
        cdb_idx_d        = rob_q[sel_idx];
        cdb_data_d       = alu_result;
      end else begin
        cdb_idx_d = ROB_W'(ROB_NONE);
      end

      // allocation only sees slots free at the start of the cycle
      if (disp_fire) begin
        valid_d[alloc_idx] = 1'b1;
        op_d[alloc_idx]    = disp_op;
        rob_d[alloc_idx]   = disp_rob_idx;
        age_d[alloc_idx]   = '0;
        vj_d[alloc_idx]    = disp_vj;
        qj_d[alloc_idx]    = disp_qj;
        vk_d[alloc_idx]    = disp_vk;
        qk_d[alloc_idx]    = disp_qk;
        if (tag_hit(disp_qj, cdb_idx_q)) begin
          vj_d[alloc_idx] = cdb_data_q;
          qj_d[alloc_idx] = '0;
        end else if (tag_hit(disp_qj, ext_cdb_idx)) begin
          vj_d[alloc_idx] = ext_cdb_data;
          qj_d[alloc_idx] = '0;
        end
        if (tag_hit(disp_qk, cdb_idx_q)) begin
          vk_d[alloc_idx] = cdb_data_q;
          qk_d[alloc_idx] = '0;
        end else if (tag_hit(disp_qk, ext_cdb_idx)) begin
          vk_d[alloc_idx] = ext_cdb_data;
          qk_d[alloc_idx] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      cdb_idx_q  <= '0;
      cdb_data_q <= '0;
      for (int i = 0; i < RS_N; i++) age_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      cdb_idx_q  <= cdb_idx_d;
      cdb_data_q <= cdb_data_d;
      for (int i = 0; i < RS_N; i++) age_q[i] <= age_d[i];
    end
  end

  // payload fields are qualified by valid_q and need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_N; i++) begin
      op_q[i]  <= op_d[i];
      rob_q[i] <= rob_d[i];
      vj_q[i]  <= vj_d[i];
      qj_q[i]  <= qj_d[i];
      vk_q[i]  <= vk_d[i];
      qk_q[i]  <= qk_d[i];
    end
  end

  assign cdb_alu_rob_idx = cdb_idx_q;
  assign cdb_alu_data    = cdb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
// ============================================================================
// tb_alu_reservation_station : directed self-checking bench for the ALU RS
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int RS_N  = 4;
  localparam int ROB_W = 3;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_op;
  logic [ROB_W-1:0] disp_rob_idx;
  logic [DW-1:0]    disp_vj;
  logic [ROB_W-1:0] disp_qj;
  logic [DW-1:0]    disp_vk;
  logic [ROB_W-1:0] disp_qk;
  logic [ROB_W-1:0] ext_cdb_idx;
  logic [DW-1:0]    ext_cdb_data;
  logic [ROB_W-1:0] cdb_alu_rob_idx;
  logic [DW-1:0]    cdb_alu_data;

  int n_checks = 0;
  int n_pass   = 0;

  alu_reservation_station #(.RS_N(RS_N), .ROB_W(ROB_W), .XLEN(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_op         (disp_op),
    .disp_rob_idx    (disp_rob_idx),
    .disp_vj         (disp_vj),
    .disp_qj         (disp_qj),
    .disp_vk         (disp_vk),
    .disp_qk         (disp_qk),
    .ext_cdb_idx     (ext_cdb_idx),
    .ext_cdb_data    (ext_cdb_data),
    .cdb_alu_rob_idx (cdb_alu_rob_idx),
    .cdb_alu_data    (cdb_alu_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // inputs change and outputs are sampled 1ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [3:0] op, input logic [ROB_W-1:0] rob,
                            input logic [DW-1:0] vj, input logic [ROB_W-1:0] qj,
                            input logic [DW-1:0] vk, input logic [ROB_W-1:0] qk);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_rob_idx = rob;
    disp_vj      = vj;
    disp_qj      = qj;
    disp_vk      = vk;
    disp_qk      = qk;
  endtask

  // dispatch a ready op from a quiet station: select next cycle, broadcast after
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [ROB_W-1:0] rob,
                        input logic [DW-1:0] exp);
    drive_disp(op, rob, a, 3'd0, b, 3'd0);
    step();
    disp_valid = 1'b0;
    check_eq({tag, "_sel_idx"}, 32'(cdb_alu_rob_idx), 32'd0);
    step();
    check_eq({tag, "_idx"}, 32'(cdb_alu_rob_idx), 32'(rob));
    check_eq({tag, "_data"}, cdb_alu_data, exp);
    step();
    check_eq({tag, "_after_idx"}, 32'(cdb_alu_rob_idx), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_rob_idx = '0;
    disp_vj = '0; disp_qj = '0; disp_vk = '0; disp_qk = '0;
    ext_cdb_idx = '0; ext_cdb_data = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_idx", 32'(cdb_alu_rob_idx), 32'd0);
    check_eq("rst_data", cdb_alu_data, 32'd0);
    check_eq("rst_ready", 32'(disp_ready), 32'd1);

    // basic ADD, result held once the tag drops
    run_op("add_basic", OP_ADD, 32'd5, 32'd7, 3'd1, 32'd12);
    check_eq("data_hold", cdb_alu_data, 32'd12);

    // dependent chain through the ALU bus
    drive_disp(OP_ADD, 3'd1, 32'd5, 3'd0, 32'd7, 3'd0);
    step();
    drive_disp(OP_SUB, 3'd2, 32'hDEAD_BEEF, 3'd1, 32'd2, 3'd0);
    step();
    disp_valid = 1'b0;
    check_eq("chain_p_idx", 32'(cdb_alu_rob_idx), 32'd1);
    check_eq("chain_p_data", cdb_alu_data, 32'd12);
    step();
    check_eq("chain_gap_idx", 32'(cdb_alu_rob_idx), 32'd0);
    step();
    check_eq("chain_c_idx", 32'(cdb_alu_rob_idx), 32'd2);
    check_eq("chain_c_data", cdb_alu_data, 32'd10);
    step();

    // fill the station with ops waiting on load tag 5
    drive_disp(OP_ADD, 3'd1, 32'hDEAD, 3'd5, 32'd1, 3'd0);
    step();
    drive_disp(OP_ADD, 3'd2, 32'hDEAD, 3'd5, 32'd2, 3'd0);
    step();
    drive_disp(OP_ADD, 3'd3, 32'hDEAD, 3'd5, 32'd10, 3'd0);
    step();
    drive_disp(OP_SUB, 3'd4, 32'hDEAD, 3'd5, 32'd1, 3'd0);
    step();
    check_eq("full_ready", 32'(disp_ready), 32'd0);
    drive_disp(OP_ADD, 3'd6, 32'd100, 3'd0, 32'd0, 3'd0);
    step();
    disp_valid = 1'b0;
    check_eq("full_ready2", 32'(disp_ready), 32'd0);
    check_eq("full_no_bcast", 32'(cdb_alu_rob_idx), 32'd0);
    ext_cdb_idx  = 3'd5;
    ext_cdb_data = 32'd3;
    step();
    ext_cdb_idx  = 3'd0;
    check_eq("wake_sel_idx", 32'(cdb_alu_rob_idx), 32'd0);
    step();
    check_eq("wake1_idx", 32'(cdb_alu_rob_idx), 32'd1);
    check_eq("wake1_data", cdb_alu_data, 32'd4);
    check_eq("wake1_ready", 32'(disp_ready), 32'd1);
    step();
    check_eq("wake2_idx", 32'(cdb_alu_rob_idx), 32'd2);
    check_eq("wake2_data", cdb_alu_data, 32'd5);
    step();
    check_eq("wake3_idx", 32'(cdb_alu_rob_idx), 32'd3);
    check_eq("wake3_data", cdb_alu_data, 32'd13);
    step();
    check_eq("wake4_idx", 32'(cdb_alu_rob_idx), 32'd4);
    check_eq("wake4_data", cdb_alu_data, 32'd2);
    step();
    check_eq("wake_end_idx", 32'(cdb_alu_rob_idx), 32'd0);

    // same-cycle bypass from the load bus
    drive_disp(OP_SRA, 3'd3, 32'd0, 3'd6, 32'd4, 3'd0);
    ext_cdb_idx  = 3'd6;
    ext_cdb_data = 32'hFFFF_FFFF;
    step();
    disp_valid  = 1'b0;
    ext_cdb_idx = 3'd0;
    check_eq("byp_sel_idx", 32'(cdb_alu_rob_idx), 32'd0);
    step();
    check_eq("byp_idx", 32'(cdb_alu_rob_idx), 32'd3);
    check_eq("byp_data", cdb_alu_data, 32'hFFFF_FFFF);
    step();

    // flush with two waiting entries and one about to issue
    drive_disp(OP_ADD, 3'd1, 32'd0, 3'd7, 32'd0, 3'd0);
    step();
    drive_disp(OP_ADD, 3'd2, 32'd0, 3'd7, 32'd0, 3'd0);
    step();
    drive_disp(OP_ADD, 3'd3, 32'd1, 3'd0, 32'd1, 3'd0);
    step();
    flush = 1'b1;
    drive_disp(OP_ADD, 3'd4, 32'd9, 3'd0, 32'd9, 3'd0);
    step();
    flush      = 1'b0;
    disp_valid = 1'b0;
    check_eq("flush_idx", 32'(cdb_alu_rob_idx), 32'd0);
    check_eq("flush_ready", 32'(disp_ready), 32'd1);
    ext_cdb_idx  = 3'd7;
    ext_cdb_data = 32'd0;
    step();
    ext_cdb_idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_quiet_idx", 32'(cdb_alu_rob_idx), 32'd0);
      step();
    end

    // arithmetic corners
    run_op("slt",   OP_SLT,  32'h8000_0000, 32'd1,  3'd1, 32'd1);
    run_op("sltu",  OP_SLTU, 32'h8000_0000, 32'd1,  3'd2, 32'd0);
    run_op("add_w", OP_ADD,  32'hFFFF_FFFF, 32'd1,  3'd3, 32'd0);
    run_op("sll",   OP_SLL,  32'd1,         32'h21, 3'd4, 32'd2);
    run_op("sra",   OP_SRA,  32'h8000_0000, 32'd4,  3'd5, 32'hF800_0000);
    run_op("srl",   OP_SRL,  32'h8000_0000, 32'd4,  3'd6, 32'h0800_0000);
    run_op("sub_w", OP_SUB,  32'd0,         32'd1,  3'd7, 32'hFFFF_FFFF);
    run_op("xor",   OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd1, 32'hFF00_0FF0);
    run_op("and",   OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd2, 32'h00F0_000F);
    run_op("or",    OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd3, 32'hFFF0_0FFF);
    run_op("undef", 4'd15,   32'd5,         32'd7,  3'd4, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
